// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore FSM that sequences the 8-bit multicycle CPU datapath. Each instruction
// runs FETCH, DECODE, an optional operand fetch and an execute phase. This takes
// 2..6 clocks per instruction. Every datapath strobe is decoded purely from the
// registered state: the FSM state plus the opcode latched in DECODE.
//
// Parameters
//   ALU_OP_W      ALU opcode width (3)
//   ACC_SEL_W     accumulator address-select width (2)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   IrToCU        opcode of the current instruction (from IR)
//   DiToCU        field byte (register pair or jump/memory address high bits)
//   CznToCU       flags {C,Z,N}
//   pcInc         PC <= PC+1
//   pcLoadEn      PC <= TR
//   PcOrTR        memory address select: 0=PC, 1=TR
//   irLoadEn      IR <= memory data
//   diLoadEn      DI <= field byte
//   trLoadEn      TR <= {DI, memory data}
//   memReadEn     memory read strobe
//   memWriteEn    memory write strobe
//   accAddrSel    accumulator address: 0=ra, 1=rb, 2=R0, 3=reserved
//   accWriteEn    accumulator write
//   regOrMem      accumulator write data: 0=ALU result reg, 1=memory data
//   aLoadEn       A <= accumulator data
//   bLoadEn       B <= accumulator data
//   RegAOr0       ALU a input: 0=A, 1=8'h00
//   RegBOr0       ALU b input: 0=B, 1=8'h00
//   aluOp         ADD 000, SUB 001, AND 010, OR 011, NOT 100, SHL 101, SHR 110
//   aluResLoadEn  ALU result register load
//   cznLoadEn     flag register load
//   halted        high while in HALT
//
// Optional feature (macro CU_PERF_CNT_EN)
//   instrRetired  16-bit retired-instruction counter
//   cycleCount    16-bit busy-cycle counter (not IDLE, not HALT)
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int ALU_OP_W  = 3,
  parameter int ACC_SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           IrToCU,
  input  logic [4:0]           DiToCU,
  input  logic [2:0]           CznToCU,
  output logic                 pcInc,
  output logic                 pcLoadEn,
  output logic                 PcOrTR,
  output logic                 irLoadEn,
  output logic                 diLoadEn,
  output logic                 trLoadEn,
  output logic                 memReadEn,
  output logic                 memWriteEn,
  output logic [ACC_SEL_W-1:0] accAddrSel,
  output logic                 accWriteEn,
  output logic                 regOrMem,
  output logic                 aLoadEn,
  output logic                 bLoadEn,
  output logic                 RegAOr0,
  output logic                 RegBOr0,
  output logic [ALU_OP_W-1:0]  aluOp,
  output logic                 aluResLoadEn,
  output logic                 cznLoadEn,
  output logic                 halted
`ifdef CU_PERF_CNT_EN
  ,
  output logic [15:0]          instrRetired,
  output logic [15:0]          cycleCount
`endif
);

  // FSM state encoding. Encodings 14 and 15 are unused and recover to IDLE.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_OPND   = 4'd3,
    S_JUMP   = 4'd4,
    S_MRD    = 4'd5,
    S_MWB    = 4'd6,
    S_SRD    = 4'd7,
    S_SWR    = 4'd8,
    S_RDA    = 4'd9,
    S_RDB    = 4'd10,
    S_EX     = 4'd11,
    S_WB     = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  // Opcodes
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JZ  = 4'h4;
  localparam logic [3:0] OP_JC  = 4'h5;
  localparam logic [3:0] OP_JN  = 4'h6;
  localparam logic [3:0] OP_ADD = 4'h7;
  localparam logic [3:0] OP_SUB = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_OR  = 4'hA;
  localparam logic [3:0] OP_NOT = 4'hB;
  localparam logic [3:0] OP_SHL = 4'hC;
  localparam logic [3:0] OP_SHR = 4'hD;
  localparam logic [3:0] OP_CMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3'd0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3'd1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(3'd2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3'd3);
  localparam logic [ALU_OP_W-1:0] ALU_NOT = ALU_OP_W'(3'd4);
  localparam logic [ALU_OP_W-1:0] ALU_SHL = ALU_OP_W'(3'd5);
  localparam logic [ALU_OP_W-1:0] ALU_SHR = ALU_OP_W'(3'd6);

  // Accumulator address selects
  localparam logic [ACC_SEL_W-1:0] SEL_RA = ACC_SEL_W'(2'd0);
  localparam logic [ACC_SEL_W-1:0] SEL_RB = ACC_SEL_W'(2'd1);
  localparam logic [ACC_SEL_W-1:0] SEL_R0 = ACC_SEL_W'(2'd2);

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] op_r;        // opcode captured in DECODE; keeps EX/WB outputs Moore
  logic       unused_field_s;

  // The field byte feeds the datapath's register/address logic directly; the
  // controller's sequencing does not depend on it.
  assign unused_field_s = ^DiToCU;

  // Map an opcode to its ALU operation. CMP is a subtract whose result is discarded.
  function automatic logic [ALU_OP_W-1:0] alu_op_of(input logic [3:0] op);
    logic [ALU_OP_W-1:0] res;
    case (op)
      OP_ADD:  res = ALU_ADD;
      OP_SUB:  res = ALU_SUB;
      OP_AND:  res = ALU_AND;
      OP_OR:   res = ALU_OR;
      OP_NOT:  res = ALU_NOT;
      OP_SHL:  res = ALU_SHL;
      OP_SHR:  res = ALU_SHR;
      OP_CMP:  res = ALU_SUB;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  // Unary ALU ops skip the B read and force the ALU b input to zero.
  function automatic logic is_unary(input logic [3:0] op);
    logic res;
    case (op)
      OP_NOT, OP_SHL, OP_SHR: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

  // Conditional jump decision from flags {C,Z,N}.
  function automatic logic jcc_taken(input logic [3:0] op, input logic [2:0] czn);
    logic res;
    case (op)
      OP_JZ:   res = czn[1];
      OP_JC:   res = czn[2];
      OP_JN:   res = czn[0];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // First state after DECODE for each opcode.
  function automatic state_t decode_next(input logic [3:0] op);
    state_t res;
    case (op)
      OP_NOP:                                    res = S_FETCH;
      OP_LDA, OP_STA, OP_JMP, OP_JZ, OP_JC, OP_JN: res = S_OPND;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_CMP:     res = S_RDA;
      OP_NOT, OP_SHL, OP_SHR:                    res = S_RDA;
      OP_HLT:                                    res = S_HALT;
      default:                                   res = S_FETCH;
    endcase
    return res;
  endfunction

  // State register and latched opcode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      op_r    <= OP_NOP;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_DECODE) begin
        op_r <= IrToCU;
      end else begin
        op_r <= op_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = S_IDLE;
    case (state_r)
      S_IDLE:   next_state_s = S_FETCH;
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: next_state_s = decode_next(IrToCU);
      S_OPND: begin
        case (op_r)
          OP_JMP:              next_state_s = S_JUMP;
          OP_JZ, OP_JC, OP_JN: next_state_s = jcc_taken(op_r, CznToCU) ? S_JUMP : S_FETCH;
          OP_LDA:              next_state_s = S_MRD;
          OP_STA:              next_state_s = S_SRD;
          default:             next_state_s = S_FETCH;
        endcase
      end
      S_JUMP:   next_state_s = S_FETCH;
      S_MRD:    next_state_s = S_MWB;
      S_MWB:    next_state_s = S_FETCH;
      S_SRD:    next_state_s = S_SWR;
      S_SWR:    next_state_s = S_FETCH;
      S_RDA:    next_state_s = is_unary(op_r) ? S_EX : S_RDB;
      S_RDB:    next_state_s = S_EX;
      S_EX:     next_state_s = (op_r == OP_CMP) ? S_FETCH : S_WB;
      S_WB:     next_state_s = S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    pcInc        = 1'b0;
    pcLoadEn     = 1'b0;
    PcOrTR       = 1'b0;
    irLoadEn     = 1'b0;
    diLoadEn     = 1'b0;
    trLoadEn     = 1'b0;
    memReadEn    = 1'b0;
    memWriteEn   = 1'b0;
    accAddrSel   = SEL_RA;
    accWriteEn   = 1'b0;
    regOrMem     = 1'b0;
    aLoadEn      = 1'b0;
    bLoadEn      = 1'b0;
    RegAOr0      = 1'b0;
    RegBOr0      = 1'b0;
    aluOp        = ALU_ADD;
    aluResLoadEn = 1'b0;
    cznLoadEn    = 1'b0;
    halted       = 1'b0;
    case (state_r)
      S_FETCH: begin
        memReadEn = 1'b1;
        PcOrTR    = 1'b0;
        irLoadEn  = 1'b1;
        diLoadEn  = 1'b1;
        pcInc     = 1'b1;
      end
      S_OPND: begin
        memReadEn = 1'b1;
        PcOrTR    = 1'b0;
        trLoadEn  = 1'b1;
        pcInc     = 1'b1;
      end
      S_JUMP: pcLoadEn = 1'b1;
      S_MRD: begin
        memReadEn = 1'b1;
        PcOrTR    = 1'b1;
      end
      S_MWB: begin
        accWriteEn = 1'b1;
        accAddrSel = SEL_R0;
        regOrMem   = 1'b1;
      end
      S_SRD: begin
        accAddrSel = SEL_R0;
        aLoadEn    = 1'b1;
      end
      // Store data is the ALU output A+0.
      S_SWR: begin
        memWriteEn = 1'b1;
        PcOrTR     = 1'b1;
        RegBOr0    = 1'b1;
        aluOp      = ALU_ADD;
      end
      S_RDA: begin
        accAddrSel = SEL_RA;
        aLoadEn    = 1'b1;
      end
      S_RDB: begin
        accAddrSel = SEL_RB;
        bLoadEn    = 1'b1;
      end
      S_EX: begin
        aluOp        = alu_op_of(op_r);
        aluResLoadEn = 1'b1;
        cznLoadEn    = 1'b1;
        RegBOr0      = is_unary(op_r);
      end
      // aluOp stays as in EX so the result path is stable through write-back.
      S_WB: begin
        accAddrSel = SEL_RA;
        accWriteEn = 1'b1;
        regOrMem   = 1'b0;
        aluOp      = alu_op_of(op_r);
      end
      S_HALT:  halted = 1'b1;
      default: begin
      end
    endcase
  end

`ifdef CU_PERF_CNT_EN
  // Performance counters. They count busy cycles and retirements into FETCH and freeze in HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrRetired <= 16'd0;
      cycleCount   <= 16'd0;
    end else begin
      if ((state_r != S_IDLE) && (state_r != S_HALT)) begin
        cycleCount <= cycleCount + 16'd1;
      end else begin
        cycleCount <= cycleCount;
      end
      if ((next_state_s == S_FETCH) && (state_r != S_IDLE)) begin
        instrRetired <= instrRetired + 16'd1;
      end else begin
        instrRetired <= instrRetired;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Self-checking bench. A sequence model expands each instruction into its
// expected per-clock output words, working from the instruction-level rules.
// Directed cases are followed by random instructions, an asynchronous reset in
// EX, and a HALT soak. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcInc;
    logic       pcLoadEn;
    logic       PcOrTR;
    logic       irLoadEn;
    logic       diLoadEn;
    logic       trLoadEn;
    logic       memReadEn;
    logic       memWriteEn;
    logic [1:0] accAddrSel;
    logic       accWriteEn;
    logic       regOrMem;
    logic       aLoadEn;
    logic       bLoadEn;
    logic       RegAOr0;
    logic       RegBOr0;
    logic [2:0] aluOp;
    logic       aluResLoadEn;
    logic       cznLoadEn;
    logic       halted;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] IrToCU;
  logic [4:0] DiToCU;
  logic [2:0] CznToCU;
  logic       pcInc, pcLoadEn, PcOrTR, irLoadEn, diLoadEn, trLoadEn;
  logic       memReadEn, memWriteEn, accWriteEn, regOrMem, aLoadEn, bLoadEn;
  logic       RegAOr0, RegBOr0, aluResLoadEn, cznLoadEn, halted;
  logic [1:0] accAddrSel;
  logic [2:0] aluOp;
`ifdef CU_PERF_CNT_EN
  logic [15:0] instrRetired, cycleCount;
  int          instr_cnt = 0;
  int          cyc_cnt   = 0;
`endif

  outs_t obs;
  outs_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .IrToCU(IrToCU), .DiToCU(DiToCU), .CznToCU(CznToCU),
    .pcInc(pcInc), .pcLoadEn(pcLoadEn), .PcOrTR(PcOrTR), .irLoadEn(irLoadEn),
    .diLoadEn(diLoadEn), .trLoadEn(trLoadEn), .memReadEn(memReadEn),
    .memWriteEn(memWriteEn), .accAddrSel(accAddrSel), .accWriteEn(accWriteEn),
    .regOrMem(regOrMem), .aLoadEn(aLoadEn), .bLoadEn(bLoadEn), .RegAOr0(RegAOr0),
    .RegBOr0(RegBOr0), .aluOp(aluOp), .aluResLoadEn(aluResLoadEn),
    .cznLoadEn(cznLoadEn), .halted(halted)
`ifdef CU_PERF_CNT_EN
    , .instrRetired(instrRetired), .cycleCount(cycleCount)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {pcInc, pcLoadEn, PcOrTR, irLoadEn, diLoadEn, trLoadEn, memReadEn,
                memWriteEn, accAddrSel, accWriteEn, regOrMem, aLoadEn, bLoadEn,
                RegAOr0, RegBOr0, aluOp, aluResLoadEn, cznLoadEn, halted};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      4'h7:    return 3'b000;
      4'h8:    return 3'b001;
      4'h9:    return 3'b010;
      4'hA:    return 3'b011;
      4'hB:    return 3'b100;
      4'hC:    return 3'b101;
      4'hD:    return 3'b110;
      4'hE:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Expand one instruction into its expected per-clock output words.
  task automatic build(input logic [3:0] op, input logic [2:0] czn);
    outs_t w;
    logic  taken;
    logic  unary;
    exp_q.delete();
    w = '0; w.memReadEn = 1'b1; w.irLoadEn = 1'b1; w.diLoadEn = 1'b1; w.pcInc = 1'b1;
    exp_q.push_back(w);
    w = '0;
    exp_q.push_back(w);
    if (op >= 4'h1 && op <= 4'h6) begin
      w = '0; w.memReadEn = 1'b1; w.trLoadEn = 1'b1; w.pcInc = 1'b1;
      exp_q.push_back(w);
      taken = (op == 4'h3) || (op == 4'h4 && czn[1]) || (op == 4'h5 && czn[2]) ||
              (op == 4'h6 && czn[0]);
      if (taken) begin
        w = '0; w.pcLoadEn = 1'b1; exp_q.push_back(w);
      end else if (op == 4'h1) begin
        w = '0; w.memReadEn = 1'b1; w.PcOrTR = 1'b1; exp_q.push_back(w);
        w = '0; w.accWriteEn = 1'b1; w.accAddrSel = 2'd2; w.regOrMem = 1'b1;
        exp_q.push_back(w);
      end else if (op == 4'h2) begin
        w = '0; w.accAddrSel = 2'd2; w.aLoadEn = 1'b1; exp_q.push_back(w);
        w = '0; w.memWriteEn = 1'b1; w.PcOrTR = 1'b1; w.RegBOr0 = 1'b1; w.aluOp = 3'b000;
        exp_q.push_back(w);
      end
    end else if (op >= 4'h7 && op <= 4'hE) begin
      unary = (op == 4'hB) || (op == 4'hC) || (op == 4'hD);
      w = '0; w.accAddrSel = 2'd0; w.aLoadEn = 1'b1; exp_q.push_back(w);
      if (!unary) begin
        w = '0; w.accAddrSel = 2'd1; w.bLoadEn = 1'b1; exp_q.push_back(w);
      end
      w = '0; w.aluOp = alu_code(op); w.aluResLoadEn = 1'b1; w.cznLoadEn = 1'b1;
      w.RegBOr0 = unary;
      exp_q.push_back(w);
      if (op != 4'hE) begin
        w = '0; w.accWriteEn = 1'b1; w.aluOp = alu_code(op); exp_q.push_back(w);
      end
    end
  endtask

  // Run one instruction, checking the first ncheck clocks (0 = all of them).
  task automatic run_instr(input logic [3:0] op, input logic [4:0] di,
                           input logic [2:0] czn, input int ncheck);
    int n;
    build(op, czn);
    n = (ncheck > 0 && ncheck < exp_q.size()) ? ncheck : exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("op%0h_clk%0d", op, i + 1), {10'd0, obs}, {10'd0, exp_q[i]});
      if (i == 0) begin
`ifdef CU_PERF_CNT_EN
        chk("instrRetired", {16'd0, instrRetired}, {16'd0, instr_cnt[15:0]});
        chk("cycleCount", {16'd0, cycleCount}, {16'd0, cyc_cnt[15:0]});
`endif
        IrToCU  = op;
        DiToCU  = di;
        CznToCU = czn;
      end
    end
`ifdef CU_PERF_CNT_EN
    cyc_cnt = cyc_cnt + n;
    if (op != 4'hF) instr_cnt++;
`endif
  endtask

  // Hold reset for one falling edge, then release and check the IDLE clock.
  task automatic reset_and_release();
    rst = 1'b1;
    #1;
    chk("rst_async", {10'd0, obs}, 32'd0);
`ifdef CU_PERF_CNT_EN
    chk("rst_instrRetired", {16'd0, instrRetired}, 32'd0);
    chk("rst_cycleCount", {16'd0, cycleCount}, 32'd0);
    instr_cnt = 0;
    cyc_cnt   = 0;
`endif
    @(negedge clk);
    chk("rst_held", {10'd0, obs}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle", {10'd0, obs}, 32'd0);
  endtask

  initial begin
    logic [3:0] op;
    rst = 1'b1; IrToCU = 4'h0; DiToCU = 5'd0; CznToCU = 3'd0;
    repeat (2) @(negedge clk);
    reset_and_release();

    // Directed instructions
    run_instr(4'h7, 5'b00110, 3'b000, 0);  // ADD
    run_instr(4'h4, 5'd3, 3'b000, 0);      // JZ not taken
    run_instr(4'h4, 5'd3, 3'b010, 0);      // JZ taken
    run_instr(4'h1, 5'd9, 3'b111, 0);      // LDA
    run_instr(4'h2, 5'd1, 3'b000, 0);      // STA
    run_instr(4'h3, 5'h1F, 3'b000, 0);     // JMP
    run_instr(4'h5, 5'd0, 3'b101, 0);      // JC taken
    run_instr(4'h6, 5'd0, 3'b110, 0);      // JN not taken
    run_instr(4'h0, 5'd0, 3'b000, 0);      // NOP
    run_instr(4'hC, 5'd5, 3'b000, 0);      // SHL
    run_instr(4'hE, 5'd5, 3'b000, 0);      // CMP

    // Random instructions, excluding HLT
    for (int k = 0; k < 80; k++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, 5'($urandom), 3'($urandom), 0);
    end

    // Asynchronous reset during EX of an ADD (clock 5)
    run_instr(4'h7, 5'b01001, 3'b000, 5);
    reset_and_release();

    // CMP then HLT, then HALT must hold regardless of inputs
    run_instr(4'hE, 5'd2, 3'b000, 0);
    run_instr(4'hF, 5'd0, 3'b000, 0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk($sformatf("halt_%0d", k), {10'd0, obs}, 32'd1);
      IrToCU  = 4'($urandom);
      CznToCU = 3'($urandom);
    end
`ifdef CU_PERF_CNT_EN
    chk("halt_instrRetired", {16'd0, instrRetired}, {16'd0, instr_cnt[15:0]});
    chk("halt_cycleCount", {16'd0, cycleCount}, {16'd0, cyc_cnt[15:0]});
`endif
    reset_and_release();
    run_instr(4'h8, 5'd6, 3'b000, 0);      // SUB after leaving HALT

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
